sti_serial_receiver: RTL and testbench

//  Receive end of the STI serial link. Rebuilds one parallel frame from the so_data/so_valid
//  bit stream and recovers the 16-bit payload, using the same length/fill/msb/low options
//  the transmitter uses. Frames are queued in a small output FIFO with a valid/ready handshake.

---
 rtl/sti_serial_receiver_if.sv | 30 +++
 rtl/sti_serial_receiver.sv | 181 ++++++++++++++++++
 tb/tb_sti_serial_receiver.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sti_serial_receiver_if.sv
// Bundle of the STI receiver's config, serial-in, frame-out and status signals.
// The slave modport is the receiver's view; the master modport is the driver/consumer view.
interface sti_serial_receiver_if;
  logic        cfg_load;
  logic [1:0]  cfg_length;
  logic        cfg_fill;
  logic        cfg_msb;
  logic        cfg_low;
  logic        si_data;
  logic        si_valid;
  logic [15:0] po_data;
  logic [31:0] po_raw;
  logic        po_valid;
  logic        po_ready;
  logic        fr_err;
  logic        fr_drop;
  logic [7:0]  frame_cnt;

  modport slave (
    input  cfg_load, cfg_length, cfg_fill, cfg_msb, cfg_low,
    input  si_data, si_valid, po_ready,
    output po_data, po_raw, po_valid, fr_err, fr_drop, frame_cnt
  );

  modport master (
    output cfg_load, cfg_length, cfg_fill, cfg_msb, cfg_low,
    output si_data, si_valid, po_ready,
    input  po_data, po_raw, po_valid, fr_err, fr_drop, frame_cnt
  );
endinterface

// File: rtl/sti_serial_receiver.sv
// STI serial link receiver: rebuilds a frame from the si_data/si_valid bit stream,
// extracts the 16-bit payload and queues {payload, raw word} in a small output FIFO.
module sti_serial_receiver #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sti_serial_receiver_if.slave  rx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

  typedef struct packed {
    logic [1:0] length;
    logic       fill;
    logic       msb;
    logic       low;
  } cfg_t;

  state_t      r_state;
  state_t      w_nextState;
  cfg_t        r_pendCfg;
  cfg_t        r_actCfg;
  logic [5:0]  r_cnt;
  logic [31:0] r_raw;
  logic [2:0]  w_lenPlus;
  logic [5:0]  w_frameLen;
  logic        w_atLen;
  logic        w_start;
  logic        w_store;
  logic        w_push;
  logic        w_err;
  logic [15:0] w_payload;

  logic [47:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic [47:0]   r_hold;
  logic [47:0]   w_head;
  logic          w_pop;
  logic          w_pushOk;
  logic          w_drop;
  logic          r_frErr;
  logic          r_frDrop;
  logic [7:0]    r_frameCnt;

  assign w_lenPlus  = {1'b0, r_actCfg.length} + 3'd1;
  assign w_frameLen = {w_lenPlus, 3'b000};
  assign w_atLen    = (r_cnt == w_frameLen);

  // Pending config may be rewritten at any time; it only takes effect at the next frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pendCfg <= '0;
    end else if (rx.cfg_load) begin
      r_pendCfg <= {rx.cfg_length, rx.cfg_fill, rx.cfg_msb, rx.cfg_low};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (rx.si_valid) w_nextState = RECV;
      RECV: begin
        if (!rx.si_valid)  w_nextState = IDLE;
        else if (w_atLen)  w_nextState = FLUSH;
      end
      FLUSH:   if (!rx.si_valid) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A frame is in error when it ends short or keeps going past N bits; the latter
  // is reported once on the first extra bit and the rest are swallowed in FLUSH.
  always_comb begin
    w_start = 1'b0;
    w_store = 1'b0;
    w_push  = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      IDLE:  w_start = rx.si_valid;
      RECV: begin
        w_store = rx.si_valid && !w_atLen;
        w_push  = !rx.si_valid && w_atLen;
        w_err   = (rx.si_valid && w_atLen) || (!rx.si_valid && !w_atLen);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_actCfg <= '0;
      r_cnt    <= '0;
      r_raw    <= '0;
    end else if (w_start) begin
      r_actCfg <= r_pendCfg;
      r_cnt    <= 6'd1;
      r_raw    <= {31'd0, rx.si_data};
    end else if (w_store) begin
      r_cnt <= r_cnt + 6'd1;
      if (r_actCfg.msb) begin
        r_raw <= {r_raw[30:0], rx.si_data};
      end else begin
        r_raw[r_cnt[4:0]] <= rx.si_data;
      end
    end
  end

  always_comb begin
    w_payload = r_raw[15:0];
    unique case (r_actCfg.length)
      2'b00:   w_payload = r_actCfg.low ? {8'h00, r_raw[7:0]} : {r_raw[7:0], 8'h00};
      2'b01:   w_payload = r_raw[15:0];
      2'b10:   w_payload = r_actCfg.fill ? r_raw[23:8]  : r_raw[15:0];
      2'b11:   w_payload = r_actCfg.fill ? r_raw[31:16] : r_raw[15:0];
      default: w_payload = r_raw[15:0];
    endcase
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign w_pop    = (r_count != '0) && rx.po_ready;
  assign w_pushOk = w_push && ((r_count != FULL_COUNT) || w_pop);
  assign w_drop   = w_push && (r_count == FULL_COUNT) && !w_pop;

  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr] <= {w_payload, r_raw};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_hold     <= '0;
      r_frErr    <= 1'b0;
      r_frDrop   <= 1'b0;
      r_frameCnt <= '0;
    end else begin
      r_frErr  <= w_err;
      r_frDrop <= w_drop;
      if (w_pushOk) begin
        r_wrPtr    <= r_wrPtr + 1'b1;
        r_frameCnt <= r_frameCnt + 8'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
        r_hold  <= r_mem[r_rdPtr];
      end
      if (w_pushOk && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_pushOk && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // When empty the outputs show the last frame popped, so they stay stable.
  assign w_head       = (r_count != '0) ? r_mem[r_rdPtr] : r_hold;
  assign rx.po_valid  = (r_count != '0);
  assign rx.po_data   = w_head[47:32];
  assign rx.po_raw    = w_head[31:0];
  assign rx.fr_err    = r_frErr;
  assign rx.fr_drop   = r_frDrop;
  assign rx.frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_sti_serial_receiver.sv
// Directed bench for sti_serial_receiver: a table of single good frames, then
// hand-written error, FIFO-overflow and mid-frame reset sequences.
module tb_sti_serial_receiver;

  typedef struct {
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    logic [31:0] word;
    logic [15:0] expData;
    logic [31:0] expRaw;
  } vec_t;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;
  int   errPulses;
  int   dropPulses;
  int   expFrames;
  vec_t vecs [9];
  logic [15:0] fifoWords [5];

  sti_serial_receiver_if rx ();

  sti_serial_receiver #(.FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx.fr_err)  errPulses++;
    if (rx.fr_drop) dropPulses++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Loads the config, then sends nbits serial bits of word and drops si_valid.
  task automatic applyStimulus(input logic [1:0] len, input logic fill, input logic msb,
                               input logic low, input logic [31:0] word, input int nbits);
    int n;
    int idx;
    n = 8 * (int'(len) + 1);
    @(posedge clk); #1;
    rx.cfg_load   = 1'b1;
    rx.cfg_length = len;
    rx.cfg_fill   = fill;
    rx.cfg_msb    = msb;
    rx.cfg_low    = low;
    @(posedge clk); #1;
    rx.cfg_load = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      rx.si_valid = 1'b1;
      if (i < n) begin
        idx = msb ? (n - 1 - i) : i;
        rx.si_data = word[idx];
      end else begin
        rx.si_data = 1'b0;
      end
      @(posedge clk); #1;
    end
    rx.si_valid = 1'b0;
    rx.si_data  = 1'b0;
  endtask

  task automatic popOne();
    rx.po_ready = 1'b1;
    @(posedge clk); #1;
    rx.po_ready = 1'b0;
  endtask

  initial begin
    int e0;
    compared   = 0;
    mismatched = 0;
    errPulses  = 0;
    dropPulses = 0;
    expFrames  = 0;

    vecs[0] = '{2'd1, 1'b0, 1'b1, 1'b0, 32'h0000A5C3, 16'hA5C3, 32'h0000A5C3};
    vecs[1] = '{2'd0, 1'b0, 1'b0, 1'b1, 32'h0000003C, 16'h003C, 32'h0000003C};
    vecs[2] = '{2'd0, 1'b0, 1'b0, 1'b0, 32'h0000003C, 16'h3C00, 32'h0000003C};
    vecs[3] = '{2'd3, 1'b1, 1'b1, 1'b0, 32'hBEEF0000, 16'hBEEF, 32'hBEEF0000};
    vecs[4] = '{2'd3, 1'b0, 1'b1, 1'b0, 32'h0000BEEF, 16'hBEEF, 32'h0000BEEF};
    vecs[5] = '{2'd2, 1'b1, 1'b1, 1'b0, 32'h0012AB00, 16'h12AB, 32'h0012AB00};
    vecs[6] = '{2'd2, 1'b0, 1'b0, 1'b0, 32'h005612AB, 16'h12AB, 32'h005612AB};
    vecs[7] = '{2'd3, 1'b1, 1'b0, 1'b0, 32'h80017FFE, 16'h8001, 32'h80017FFE};
    vecs[8] = '{2'd1, 1'b0, 1'b0, 1'b1, 32'h00001234, 16'h1234, 32'h00001234};

    reset_n       = 1'b0;
    rx.cfg_load   = 1'b0;
    rx.cfg_length = 2'd0;
    rx.cfg_fill   = 1'b0;
    rx.cfg_msb    = 1'b0;
    rx.cfg_low    = 1'b0;
    rx.si_data    = 1'b0;
    rx.si_valid   = 1'b0;
    rx.po_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset po_valid",  32'(rx.po_valid),  32'd0);
    checkOutput("reset po_data",   32'(rx.po_data),   32'd0);
    checkOutput("reset po_raw",    rx.po_raw,         32'd0);
    checkOutput("reset frame_cnt", 32'(rx.frame_cnt), 32'd0);
    checkOutput("reset fr_err",    32'(rx.fr_err),    32'd0);
    checkOutput("reset fr_drop",   32'(rx.fr_drop),   32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].len, vecs[v].fill, vecs[v].msb, vecs[v].low, vecs[v].word,
                    8 * (int'(vecs[v].len) + 1));
      checkOutput($sformatf("vec%0d po_valid before push", v), 32'(rx.po_valid), 32'd0);
      @(posedge clk); #1;
      expFrames++;
      checkOutput($sformatf("vec%0d po_valid", v),  32'(rx.po_valid),  32'd1);
      checkOutput($sformatf("vec%0d po_data", v),   32'(rx.po_data),   32'(vecs[v].expData));
      checkOutput($sformatf("vec%0d po_raw", v),    rx.po_raw,         vecs[v].expRaw);
      checkOutput($sformatf("vec%0d frame_cnt", v), 32'(rx.frame_cnt), 32'(expFrames));
      popOne();
      checkOutput($sformatf("vec%0d po_valid after pop", v), 32'(rx.po_valid), 32'd0);
      checkOutput($sformatf("vec%0d po_data hold", v), 32'(rx.po_data), 32'(vecs[v].expData));
    end
    checkOutput("table fr_err pulses", 32'(errPulses), 32'd0);

    // Short frame: 10 bits of a 16-bit frame.
    e0 = errPulses;
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 32'h0000FFFF, 10);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("short fr_err pulses", 32'(errPulses - e0), 32'd1);
    checkOutput("short po_valid",      32'(rx.po_valid),    32'd0);
    checkOutput("short frame_cnt",     32'(rx.frame_cnt),   32'(expFrames));

    // Long frame: 17 bits of a 16-bit frame, then a good frame.
    e0 = errPulses;
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 32'h00005A5A, 17);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("long fr_err pulses", 32'(errPulses - e0), 32'd1);
    checkOutput("long po_valid",      32'(rx.po_valid),    32'd0);
    checkOutput("long frame_cnt",     32'(rx.frame_cnt),   32'(expFrames));
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 32'h0000CAFE, 16);
    @(posedge clk); #1;
    expFrames++;
    checkOutput("after long po_valid", 32'(rx.po_valid), 32'd1);
    checkOutput("after long po_data",  32'(rx.po_data),  32'h0000CAFE);
    popOne();

    // Overflow: five frames with no consumer, FIFO keeps the first four.
    fifoWords[0] = 16'h1111;
    fifoWords[1] = 16'h2222;
    fifoWords[2] = 16'h3333;
    fifoWords[3] = 16'h4444;
    fifoWords[4] = 16'h5555;
    e0 = dropPulses;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, {16'h0, fifoWords[k]}, 16);
    end
    expFrames += 4;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("overflow fr_drop pulses", 32'(dropPulses - e0), 32'd1);
    checkOutput("overflow frame_cnt",      32'(rx.frame_cnt),    32'(expFrames));
    rx.po_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("overflow out%0d po_valid", k), 32'(rx.po_valid), 32'd1);
      checkOutput($sformatf("overflow out%0d po_data", k),  32'(rx.po_data),  32'(fifoWords[k]));
      @(posedge clk); #1;
    end
    rx.po_ready = 1'b0;
    checkOutput("overflow drained po_valid", 32'(rx.po_valid), 32'd0);

    // Reset with one frame queued and another half received.
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 32'h00007777, 16);
    @(posedge clk); #1;
    checkOutput("pre-reset po_valid", 32'(rx.po_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      rx.si_valid = 1'b1;
      rx.si_data  = i[0];
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    expFrames = 0;
    checkOutput("midreset po_valid",  32'(rx.po_valid),  32'd0);
    checkOutput("midreset po_data",   32'(rx.po_data),   32'd0);
    checkOutput("midreset po_raw",    rx.po_raw,         32'd0);
    checkOutput("midreset frame_cnt", 32'(rx.frame_cnt), 32'd0);
    rx.si_valid = 1'b0;
    rx.si_data  = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 32'h00001234, 16);
    @(posedge clk); #1;
    expFrames++;
    checkOutput("postreset po_valid",  32'(rx.po_valid),  32'd1);
    checkOutput("postreset po_data",   32'(rx.po_data),   32'h00001234);
    checkOutput("postreset po_raw",    rx.po_raw,         32'h00001234);
    checkOutput("postreset frame_cnt", 32'(rx.frame_cnt), 32'(expFrames));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
